// File: rtl/qsim_pkg.sv
// Shared opcodes, FSM encoding and decoded-operation type for the qsim state-vector core.
// Legality of qubit operands is resolved once at decode so the datapath only sees executable ops.
package qsim_pkg;

  localparam logic [2:0] OPC_H    = 3'b000;
  localparam logic [2:0] OPC_X    = 3'b001;
  localparam logic [2:0] OPC_CNOT = 3'b010;
  localparam logic [2:0] OPC_Z    = 3'b011;
  localparam logic [2:0] OPC_INIT = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } qsim_state_t;

  // OP_ILL marks a gate whose qubit operands are out of range or collide.
  typedef enum logic [2:0] {
    OP_H    = OPC_H,
    OP_X    = OPC_X,
    OP_CNOT = OPC_CNOT,
    OP_Z    = OPC_Z,
    OP_INIT = OPC_INIT,
    OP_NOP  = 3'b101,
    OP_ILL  = 3'b111
  } qsim_op_t;

  function automatic logic qsim_is_gate(input qsim_op_t op);
    return (op == OP_H) || (op == OP_X) || (op == OP_CNOT) || (op == OP_Z);
  endfunction

  function automatic qsim_op_t qsim_decode(input logic [2:0] opc,
                                           input logic [1:0] q1,
                                           input logic [1:0] q2,
                                           input logic [2:0] nq);
    qsim_op_t op;
    case (opc)
      OPC_H:    op = OP_H;
      OPC_X:    op = OP_X;
      OPC_CNOT: op = OP_CNOT;
      OPC_Z:    op = OP_Z;
      OPC_INIT: op = OP_INIT;
      default:  op = OP_NOP;
    endcase
    if (qsim_is_gate(op)) begin
      if ({1'b0, q1} >= nq) begin
        op = OP_ILL;
      end else if ((op == OP_CNOT) && (({1'b0, q2} >= nq) || (q1 == q2))) begin
        op = OP_ILL;
      end
    end
    return op;
  endfunction

endpackage

// File: rtl/qsim_pair_alu.sv
// Combinational butterfly for one amplitude pair (H/X/Z/CNOT), zero latency, no flow control.
// Define QSIM_SAT_EN to clamp results to the AW-bit signed range instead of wrapping.
module qsim_pair_alu
  import qsim_pkg::*;
#(
  parameter int AW = 8
) (
  input  qsim_op_t               op,
  input  logic                   ctrl,
  input  logic signed [AW-1:0]   a0,
  input  logic signed [AW-1:0]   a1,
  output logic signed [AW-1:0]   y0,
  output logic signed [AW-1:0]   y1
);

  // A result needs clamping only when its top two bits disagree.
  function automatic logic signed [AW:0] clamp(input logic signed [AW:0] x);
`ifdef QSIM_SAT_EN
    if (x[AW] != x[AW-1]) begin
      return x[AW] ? {2'b11, {(AW-1){1'b0}}} : {2'b00, {(AW-1){1'b1}}};
    end
`endif
    return x;
  endfunction

  logic signed [AW:0] ax0;
  logic signed [AW:0] ax1;
  logic signed [AW:0] sum_h;
  logic signed [AW:0] dif_h;
  logic signed [AW:0] neg1;

  always_comb begin
    ax0   = {a0[AW-1], a0};
    ax1   = {a1[AW-1], a1};
    sum_h = (ax0 + ax1) >>> 1;
    dif_h = (ax0 - ax1) >>> 1;
    neg1  = -ax1;
  end

  always_comb begin
    y0 = a0;
    y1 = a1;
    case (op)
      OP_H: begin
        y0 = AW'(clamp(sum_h));
        y1 = AW'(clamp(dif_h));
      end
      OP_X: begin
        y0 = a1;
        y1 = a0;
      end
      OP_Z: begin
        y1 = AW'(clamp(neg1));
      end
      OP_CNOT: begin
        if (ctrl) begin
          y0 = a1;
          y1 = a0;
        end
      end
      default: begin
        y0 = a0;
        y1 = a1;
      end
    endcase
  end

endmodule

// File: rtl/qsim_core.sv
// qsim_core: NQ-qubit state-vector gate engine, one amplitude pair per cycle; accept-to-done 2^(NQ-1)+1 cycles.
// instr_ready only in IDLE, so offers during EXEC/DONE stall; QSIM_SAT_EN selects clamping over wrap.
module qsim_core
  import qsim_pkg::*;
#(
  parameter int NQ       = 2,
  parameter int AW       = 8,
  parameter int INIT_AMP = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic [2:0]                opcode,
  input  logic [1:0]                qubit1,
  input  logic [1:0]                qubit2,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [AW*(1<<NQ)-1:0]     out_state_flat
);

  localparam int NS = 1 << NQ;
  localparam int NP = NS / 2;
  localparam int KW = NQ - 1;
  localparam logic [2:0]           NQ3  = 3'(NQ);
  localparam logic signed [AW-1:0] AMP0 = AW'(INIT_AMP);

  qsim_state_t state_q, state_d;
  qsim_op_t    op_q, op_d;
  logic [KW-1:0] k_q, k_d;
  logic [1:0]  q1_q, q1_d;
  logic [1:0]  q2_q, q2_d;
  logic        err_q, err_d;
  logic signed [AW-1:0] amp_q [NS];
  logic signed [AW-1:0] amp_d [NS];

  logic [1:0]    tgt;
  logic [1:0]    pos;
  logic [1:0]    cpos;
  logic [NQ-1:0] kx;
  logic [NQ-1:0] lo_mask;
  logic [NQ-1:0] i0;
  logic [NQ-1:0] i1;
  logic          ctrl;
  logic          exec_last;
  logic signed [AW-1:0] y0;
  logic signed [AW-1:0] y1;

  // Pair indices: counter k with a zero spliced in at the target bit (qubit 0 is the index MSB).
  always_comb begin
    tgt       = (op_q == OP_CNOT) ? q2_q : q1_q;
    pos       = 2'(NQ - 1) - tgt;
    cpos      = 2'(NQ - 1) - q1_q;
    kx        = NQ'(k_q);
    lo_mask   = (NQ'(1) << pos) - NQ'(1);
    i0        = ((kx & ~lo_mask) << 1) | (kx & lo_mask);
    i1        = i0 | (NQ'(1) << pos);
    ctrl      = |(i0 & (NQ'(1) << cpos));
    exec_last = !qsim_is_gate(op_q) || (k_q == KW'(NP - 1));
  end

  qsim_pair_alu #(.AW(AW)) u_alu (
    .op   (op_q),
    .ctrl (ctrl),
    .a0   (amp_q[i0]),
    .a1   (amp_q[i1]),
    .y0   (y0),
    .y1   (y1)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (instr_valid) state_d = ST_EXEC;
      ST_EXEC: if (exec_last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state_q == ST_IDLE);
    busy        = (state_q == ST_EXEC) || (state_q == ST_DONE);
    done        = (state_q == ST_DONE);
  end

  always_comb begin
    amp_d = amp_q;
    op_d  = op_q;
    k_d   = k_q;
    q1_d  = q1_q;
    q2_d  = q2_q;
    err_d = err_q;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          op_d = qsim_decode(opcode, qubit1, qubit2, NQ3);
          q1_d = qubit1;
          q2_d = qubit2;
          k_d  = '0;
        end
      end
      ST_EXEC: begin
        if (op_q == OP_INIT) begin
          for (int i = 0; i < NS; i++) amp_d[i] = '0;
          amp_d[0] = AMP0;
        end else if (qsim_is_gate(op_q)) begin
          amp_d[i0] = y0;
          amp_d[i1] = y1;
        end else if (op_q == OP_ILL) begin
          err_d = 1'b1;
        end
        k_d = exec_last ? '0 : k_q + 1'b1;
      end
      default: begin
        k_d = k_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q  <= OP_NOP;
      k_q   <= '0;
      q1_q  <= '0;
      q2_q  <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < NS; i++) amp_q[i] <= (i == 0) ? AMP0 : '0;
    end else begin
      op_q  <= op_d;
      k_q   <= k_d;
      q1_q  <= q1_d;
      q2_q  <= q2_d;
      err_q <= err_d;
      for (int i = 0; i < NS; i++) amp_q[i] <= amp_d[i];
    end
  end

  assign err = err_q;

  always_comb begin
    out_state_flat = '0;
    for (int i = 0; i < NS; i++) out_state_flat[AW*(NS-1-i) +: AW] = amp_q[i];
  end

endmodule

// File: tb/tb_qsim_core.sv
// Two qsim_core instances (INIT_AMP 10 and 127) driven in lockstep against a gate-level state-vector model.
// Directed gate sequences, mid-gate reset and randomized instructions; build with QSIM_SAT_EN for the clamping variant.
module tb_qsim_core;

  localparam int NQ = 2;
  localparam int AW = 8;
  localparam int NS = 1 << NQ;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic instr_valid = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic [1:0] qubit1 = 2'd0;
  logic [1:0] qubit2 = 2'd0;

  logic rdy0, busy0, done0, err0;
  logic rdy1, busy1, done1, err1;
  logic [AW*NS-1:0] flat0, flat1;

  qsim_core #(.NQ(NQ), .AW(AW), .INIT_AMP(10)) u_dut0 (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(rdy0),
    .opcode(opcode), .qubit1(qubit1), .qubit2(qubit2),
    .busy(busy0), .done(done0), .err(err0), .out_state_flat(flat0)
  );

  qsim_core #(.NQ(NQ), .AW(AW), .INIT_AMP(127)) u_dut1 (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(rdy1),
    .opcode(opcode), .qubit1(qubit1), .qubit2(qubit2),
    .busy(busy1), .done(done1), .err(err1), .out_state_flat(flat1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int acc_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (instr_valid && rdy0) acc_cnt <= acc_cnt + 1;
  end

  int n_chk = 0;
  int n_fail = 0;
  int m [2][NS];
  bit m_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int init_of(input int d);
    return (d == 0) ? 10 : 127;
  endfunction

  function automatic int fit(input int x);
    int v;
`ifdef QSIM_SAT_EN
    v = (x > 127) ? 127 : ((x < -128) ? -128 : x);
`else
    v = x & 255;
    if (v >= 128) v = v - 256;
`endif
    return v;
  endfunction

  function automatic bit is_illegal(input int opc, input int q1, input int q2);
    if (opc > 3) return 1'b0;
    if (q1 >= NQ) return 1'b1;
    if (opc == 2 && (q2 >= NQ || q1 == q2)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int exp_lat(input int opc, input int q1, input int q2);
    if (opc <= 3 && !is_illegal(opc, q1, q2)) return (1 << (NQ - 1)) + 1;
    return 2;
  endfunction

  function automatic logic [AW*NS-1:0] exp_flat(input int d);
    logic [AW*NS-1:0] f;
    int v;
    f = '0;
    for (int i = 0; i < NS; i++) begin
      v = m[d][i];
      f[AW*(NS-1-i) +: AW] = v[AW-1:0];
    end
    return f;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NS; i++) m[d][i] = 0;
      m[d][0] = init_of(d);
    end
    m_err = 1'b0;
  endtask

  // Apply a gate to the full state vector: every index with target bit clear pairs with its partner.
  task automatic model_apply(input int opc, input int q1, input int q2);
    int t, tm, cm, j, a, b;
    if (is_illegal(opc, q1, q2)) begin
      m_err = 1'b1;
      return;
    end
    if (opc == 4) begin
      model_reset_amps();
      return;
    end
    if (opc > 3) return;
    t  = (opc == 2) ? q2 : q1;
    tm = 1 << (NQ - 1 - t);
    cm = 1 << (NQ - 1 - q1);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NS; i++) begin
        if ((i & tm) == 0) begin
          j = i | tm;
          a = m[d][i];
          b = m[d][j];
          case (opc)
            0: begin m[d][i] = fit((a + b) >>> 1); m[d][j] = fit((a - b) >>> 1); end
            1: begin m[d][i] = b; m[d][j] = a; end
            2: if ((i & cm) != 0) begin m[d][i] = b; m[d][j] = a; end
            default: m[d][j] = fit(-b);
          endcase
        end
      end
    end
  endtask

  task automatic model_reset_amps();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NS; i++) m[d][i] = 0;
      m[d][0] = init_of(d);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_st0"}, flat0, exp_flat(0));
    chk({tag, "_st1"}, flat1, exp_flat(1));
    chk({tag, "_err"}, err0, m_err);
  endtask

  // Offer one instruction, hold instr_valid until done, then compare timing and state.
  task automatic run_instr(input int opc, input int q1, input int q2, input string tag);
    int c0, a0, n;
    bit seen;
    @(posedge clk); #1;
    chk({tag, "_idle"}, {rdy0, done0, busy0}, 3'b100);
    opcode = 3'(opc);
    qubit1 = 2'(q1);
    qubit2 = 2'(q2);
    instr_valid = 1'b1;
    c0 = cyc;
    a0 = acc_cnt;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done0) seen = 1'b1;
    end
    chk({tag, "_lat"}, seen ? (cyc - c0) : -1, exp_lat(opc, q1, q2));
    chk({tag, "_done"}, {done1, busy0, rdy0}, 3'b110);
    instr_valid = 1'b0;
    model_apply(opc, q1, q2);
    chk({tag, "_acc"}, acc_cnt - a0, 1);
    check_state(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    chk({tag, "_ctl"}, {rdy0, busy0, done0, err0}, 4'b1000);
    check_state(tag);
  endtask

  initial begin
    int opc, q1, q2;
    model_reset();
    @(posedge clk); #1;
    do_reset("reset");
    chk("reset_const", flat0, 32'h0A000000);

    run_instr(0, 0, 0, "h_q0");
    chk("h_q0_const", flat0, 32'h05000500);
    run_instr(2, 0, 1, "cnot01");
    chk("bell_const", flat0, 32'h05000005);

    run_instr(4, 0, 0, "init_a");
    run_instr(1, 1, 0, "x_q1");
    run_instr(3, 1, 0, "z_q1");
    chk("xz_const", flat0, 32'h00F60000);
    run_instr(4, 2, 3, "init_b");
    chk("init_const", flat0, 32'h0A000000);

    run_instr(2, 1, 1, "cnot11");
    chk("cnot11_err", err0, 1'b1);
    chk("cnot11_const", flat0, 32'h0A000000);
    run_instr(4, 0, 0, "init_sticky");
    run_instr(0, 3, 0, "h_q3");

    do_reset("reset2");
    run_instr(0, 0, 0, "hxh_h1");
    run_instr(1, 0, 0, "hxh_x");
    run_instr(0, 0, 0, "hxh_h2");
    chk("hxh127_const", flat1, 32'h3F000000);

    // Reset while the second pair of an H is still pending.
    @(posedge clk); #1;
    opcode = 3'd0; qubit1 = 2'd0; qubit2 = 2'd0;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("midexec_busy", busy0, 1'b1);
    do_reset("midexec_rst");

    for (int r = 0; r < 40; r++) begin
      opc = int'($urandom_range(0, 7));
      q1  = int'($urandom_range(0, 3));
      q2  = int'($urandom_range(0, 3));
      run_instr(opc, q1, q2, $sformatf("rnd%0d_op%0d", r, opc));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/qsim_core.md
QSIM_CORE -- requirements
Module: qsim_core

Interface
REQ-001 SHALL have parameter NQ, default 2, meaning qubit count (legal 2..4); state vector holds 2^NQ amplitudes.
REQ-002 SHALL have parameter AW, default 8, meaning signed real amplitude width.
REQ-003 SHALL have parameter INIT_AMP, default 10, meaning amplitude loaded into basis state |0..0> on reset or INIT.
REQ-004 SHALL have port clk  in  1  meaning sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  meaning synchronous, active-high reset.
REQ-006 SHALL have port instr_valid  in  1  meaning instruction offered.
REQ-007 SHALL have port instr_ready  out  1  meaning core accepts an instruction this cycle.
REQ-008 SHALL have port opcode  in  3  meaning gate select: 000 H, 001 X, 010 CNOT, 011 Z, 100 INIT, others NOP.
REQ-009 SHALL have port qubit1  in  2  meaning target qubit (H/X/Z) or control qubit (CNOT).
REQ-010 SHALL have port qubit2  in  2  meaning CNOT target qubit; ignored otherwise.
REQ-011 SHALL have port busy  out  1  meaning gate executing.
REQ-012 SHALL have port done  out  1  meaning one-cycle pulse on gate completion.
REQ-013 SHALL have port err  out  1  meaning sticky illegal-operand flag.
REQ-014 SHALL have port out_state_flat  out  AW*2^NQ  meaning amplitudes, amp[0] in MSBs, amp[2^NQ-1] in LSBs.

Function
REQ-015 SHALL map qubit q to basis-index bit NQ-1-q (qubit 0 = MSB).
REQ-016 SHALL run FSM IDLE->EXEC->DONE->IDLE; instr_ready=1 only in IDLE; handshake on instr_valid&&instr_ready captures opcode/qubits into registers.
REQ-017 SHALL in EXEC process one amplitude pair per cycle: counter k=0..2^(NQ-1)-1, i0=k with 0 inserted at target bit, i1=i0 with target bit set; EXEC lasts 2^(NQ-1) cycles.
REQ-018 SHALL for H write amp[i0]=(a0+a1)>>>1, amp[i1]=(a0-a1)>>>1, sums computed at AW+1 bits.
REQ-019 SHALL for X swap amp[i0] and amp[i1].
REQ-020 SHALL for Z write amp[i1]=-amp[i1]; amp[i0] unchanged.
REQ-021 SHALL for CNOT swap amp[i0]/amp[i1] (target=qubit2) only when control bit of i0 is 1.
REQ-022 SHALL for INIT load all amplitudes to 0 and amp[0]=INIT_AMP in one EXEC cycle.
REQ-023 SHALL for NOP spend one EXEC cycle with no state change.
REQ-024 SHALL treat qubit1>=NQ, or CNOT with qubit2>=NQ or qubit1==qubit2, as illegal: set err, no state change, one EXEC cycle.
REQ-025 SHALL assert done for exactly the DONE cycle; busy=1 in EXEC and DONE; accept-to-done latency 2^(NQ-1)+1 cycles for gates.
REQ-026 SHALL ignore instr_valid while not IDLE; err clears only on reset.

Reset
REQ-027 SHALL on reset enter IDLE, clear k, done, busy, err, and load amp[0]=INIT_AMP, others 0.
REQ-028 SHALL, on reset mid-EXEC, abandon the gate; partially updated amplitudes are overwritten by reset values.

Configuration
REQ-029 SHALL with QSIM_SAT_EN defined clamp every written amplitude (including H results and negation of -2^(AW-1)) to [-2^(AW-1), 2^(AW-1)-1]; without it, results truncate to AW bits (two's-complement wrap).

Structure
REQ-030 SHALL take opcode constants, FSM state encoding and the qsim_op_t typedef from package qsim_pkg.
REQ-031 SHALL place pair arithmetic (H/X/Z/CNOT butterfly, saturation) in combinational sub-module qsim_pair_alu.

Verification (NQ=2, AW=8)
REQ-032 SHALL cover reset -> out_state_flat=0x0A000000, instr_ready=1, err=0.
REQ-033 SHALL cover H on qubit 0 after reset -> 0x05000500, done 3 cycles after accept.
REQ-034 SHALL cover H q0 then CNOT(0,1) -> 0x05000005 (Bell-like).
REQ-035 SHALL cover X q1 then Z q1 -> 0x00F60000; INIT -> 0x0A000000.
REQ-036 SHALL cover CNOT(1,1) -> err=1, state unchanged; instr_valid held during EXEC -> single acceptance.
REQ-037 SHALL cover INIT_AMP=127, H q0 then X q0 then H q0 -> results checked against QSIM_SAT_EN on/off golden values.
